// File: rtl/aud_adc_rx.sv
// I2S receiver for the codec ADC path: deserializes left/right pairs into a small FWFT FIFO.
// Optional peak-magnitude outputs are built when AUD_RX_PEAK_EN is defined.
module aud_adc_rx #(
    parameter int DATA_W      = 24,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          aud_bclk,
    input  logic                          aud_adclrck,
    input  logic                          aud_adcdat,
    input  logic                          enable,
    output logic                          sample_valid,
    input  logic                          sample_ready,
    output logic [DATA_W-1:0]             sample_left,
    output logic [DATA_W-1:0]             sample_right,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          frame_err,
    input  logic                          err_clear
`ifdef AUD_RX_PEAK_EN
    ,
    output logic [DATA_W-2:0]             peak_left,
    output logic [DATA_W-2:0]             peak_right
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(DATA_W + 1);

    localparam logic [2:0] SYNC_WAIT = 3'd0;
    localparam logic [2:0] LEFT      = 3'd1;
    localparam logic [2:0] LEFT_PAD  = 3'd2;
    localparam logic [2:0] RIGHT     = 3'd3;
    localparam logic [2:0] RIGHT_PAD = 3'd4;

    logic [SYNC_STAGES-1:0] bclk_sync, lrck_sync, dat_sync;
    logic                   bclk_s, lrck_s, dat_s;
    logic                   bclk_prev, lrck_prev;
    logic                   brise, lrck_chg, lrck_fall, lrck_rise;

    assign bclk_s    = bclk_sync[SYNC_STAGES-1];
    assign lrck_s    = lrck_sync[SYNC_STAGES-1];
    assign dat_s     = dat_sync[SYNC_STAGES-1];
    assign brise     = bclk_s & ~bclk_prev;
    assign lrck_chg  = brise & (lrck_s != lrck_prev);
    assign lrck_fall = lrck_chg & ~lrck_s;
    assign lrck_rise = lrck_chg & lrck_s;

    // LRCK is only compared between bit-clock rises, so it is tracked at brise only
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bclk_sync <= '0;
            lrck_sync <= '0;
            dat_sync  <= '0;
            bclk_prev <= 1'b0;
            lrck_prev <= 1'b0;
        end else begin
            bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], aud_bclk};
            lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], aud_adclrck};
            dat_sync  <= {dat_sync[SYNC_STAGES-2:0], aud_adcdat};
            bclk_prev <= bclk_s;
            if (brise)
                lrck_prev <= lrck_s;
        end
    end

    logic [2:0]        state;
    logic [CW-1:0]     bit_cnt;
    logic [DATA_W-1:0] shift_reg, left_word, right_word, shifted;
    logic              last_bit, push, frame_set;

    assign shifted   = {shift_reg[DATA_W-2:0], dat_s};
    assign last_bit  = (bit_cnt == CW'(DATA_W - 1));
    assign frame_set = enable & lrck_chg & ((state == LEFT) | (state == RIGHT));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= SYNC_WAIT;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            left_word  <= '0;
            right_word <= '0;
            push       <= 1'b0;
        end else begin
            push <= 1'b0;
            if (!enable) begin
                state <= SYNC_WAIT;
            end else if (brise) begin
                case (state)
                    SYNC_WAIT: begin
                        if (lrck_fall) begin
                            state   <= LEFT;
                            bit_cnt <= '0;
                        end
                    end
                    LEFT: begin
                        if (lrck_fall) begin
                            bit_cnt <= '0;
                        end else if (lrck_rise) begin
                            state <= SYNC_WAIT;
                        end else begin
                            shift_reg <= shifted;
                            bit_cnt   <= bit_cnt + CW'(1);
                            if (last_bit) begin
                                left_word <= shifted;
                                state     <= LEFT_PAD;
                            end
                        end
                    end
                    LEFT_PAD: begin
                        if (lrck_rise) begin
                            state   <= RIGHT;
                            bit_cnt <= '0;
                        end else if (lrck_fall) begin
                            state   <= LEFT;
                            bit_cnt <= '0;
                        end
                    end
                    RIGHT: begin
                        if (lrck_fall) begin
                            state   <= LEFT;
                            bit_cnt <= '0;
                        end else if (lrck_rise) begin
                            state <= SYNC_WAIT;
                        end else begin
                            shift_reg <= shifted;
                            bit_cnt   <= bit_cnt + CW'(1);
                            if (last_bit) begin
                                right_word <= shifted;
                                push       <= 1'b1;
                                state      <= RIGHT_PAD;
                            end
                        end
                    end
                    RIGHT_PAD: begin
                        if (lrck_fall) begin
                            state   <= LEFT;
                            bit_cnt <= '0;
                        end
                    end
                    default: state <= SYNC_WAIT;
                endcase
            end
        end
    end

    logic [DATA_W-1:0] mem_left  [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_right [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [LW-1:0]     count;
    logic              full, pop, push_ok, overflow_set;

    assign full         = (count == LW'(FIFO_DEPTH));
    assign pop          = sample_valid & sample_ready;
    assign push_ok      = push & (~full | pop);
    assign overflow_set = push & full & ~pop;
    assign sample_valid = (count != '0);
    assign sample_left  = mem_left[rd_ptr];
    assign sample_right = mem_right[rd_ptr];
    assign fifo_level   = count;

    // A push into a full FIFO is only accepted when the head leaves in the same cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_left[i]  <= '0;
                mem_right[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem_left[wr_ptr]  <= left_word;
                mem_right[wr_ptr] <= right_word;
                wr_ptr            <= wr_ptr + AW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + LW'(push_ok) - LW'(pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            overflow  <= (overflow & ~err_clear) | overflow_set;
            frame_err <= (frame_err & ~err_clear) | frame_set;
        end
    end

`ifdef AUD_RX_PEAK_EN
    localparam int PW = DATA_W - 1;

    // The most negative code has no positive twin, so it saturates to all ones
    function automatic logic [PW-1:0] magnitude(input logic [DATA_W-1:0] s);
        if (!s[DATA_W-1])
            magnitude = s[PW-1:0];
        else if (s[PW-1:0] == '0)
            magnitude = '1;
        else
            magnitude = ~s[PW-1:0] + PW'(1);
    endfunction

    logic [PW-1:0] mag_left, mag_right;
    assign mag_left  = magnitude(left_word);
    assign mag_right = magnitude(right_word);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            peak_left  <= '0;
            peak_right <= '0;
        end else if (err_clear) begin
            peak_left  <= '0;
            peak_right <= '0;
        end else if (push_ok) begin
            if (mag_left > peak_left)
                peak_left <= mag_left;
            if (mag_right > peak_right)
                peak_right <= mag_right;
        end
    end
`endif

endmodule
